// File: rtl/biquad_pkg.sv
// Shared definitions for the biquad coefficient path: default word width,
// loader FSM states and the DSP-pair word ordering.
package biquad_pkg;

    localparam int COEFF_BITS_DEF = 18;

    // The cascaded B-register chain expects the highest address first.
    localparam bit HIGH_WORD_FIRST = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        SNAP,
        SHIFT,
        GAP,
        UPDATE
    } state_e;

endpackage

// File: rtl/biquad8_coeff_loader.sv
// Shadow-bank coefficient loader: snapshot on commit, serialize onto the biquad
// coefficient bus, then strobe update. Optional readback via BIQUAD_COEFF_READBACK_EN.
module biquad8_coeff_loader
    import biquad_pkg::*;
#(
    parameter int COEFF_BITS = COEFF_BITS_DEF,
    parameter int NWORDS     = 2,
    parameter int ADR_BITS   = 1,
    parameter int UPDATE_GAP = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADR_BITS-1:0]   host_adr_i,
    input  logic [COEFF_BITS-1:0] host_dat_i,
    input  logic                  host_wr_i,
    input  logic                  host_commit_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [COEFF_BITS-1:0] coeff_dat_o,
    output logic                  coeff_wr_o,
`ifdef BIQUAD_COEFF_READBACK_EN
    input  logic [ADR_BITS-1:0]   rb_adr_i,
    output logic [COEFF_BITS-1:0] rb_dat_o,
`endif
    output logic                  coeff_update_o
);

    localparam int              WIDX     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [WIDX-1:0] LAST_IDX = WIDX'(NWORDS - 1);
    localparam logic [3:0]      GAP_LOAD = 4'((UPDATE_GAP > 0) ? UPDATE_GAP - 1 : 0);

    state_e                  state_q, state_d;
    logic                    pending_q, pending_d;
    logic [WIDX-1:0]         word_cnt_q, word_cnt_d;
    logic [3:0]              gap_cnt_q, gap_cnt_d;
    logic [COEFF_BITS-1:0]   shadow_q [NWORDS];
    logic [COEFF_BITS-1:0]   shadow_d [NWORDS];
    logic [COEFF_BITS-1:0]   snap_q [NWORDS];
    logic [COEFF_BITS-1:0]   snap_d [NWORDS];
    logic                    busy_q, busy_d;
    logic                    wr_q, wr_d;
    logic                    upd_q, upd_d;
    logic [COEFF_BITS-1:0]   dat_q, dat_d;
    logic [WIDX-1:0]         sel_idx;
    logic [COEFF_BITS-1:0]   src_word;

    always_comb begin
        shadow_d = shadow_q;
        if (host_wr_i && (int'(host_adr_i) < NWORDS)) begin
            shadow_d[host_adr_i[WIDX-1:0]] = host_dat_i;
        end
    end

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        word_cnt_d = word_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        snap_d     = snap_q;

        case (state_q)
            IDLE: begin
                if (host_commit_i || pending_q) begin
                    state_d   = SNAP;
                    pending_d = 1'b0;
                end
            end
            SNAP: begin
                snap_d     = shadow_q;
                word_cnt_d = LAST_IDX;
                state_d    = SHIFT;
            end
            SHIFT: begin
                if (word_cnt_q == '0) begin
                    if (UPDATE_GAP == 0) begin
                        state_d = UPDATE;
                    end else begin
                        state_d   = GAP;
                        gap_cnt_d = GAP_LOAD;
                    end
                end else begin
                    word_cnt_d = word_cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = UPDATE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            UPDATE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A commit that arrives while a sequence is in flight (UPDATE included) is deferred.
        if (host_commit_i && (state_q != IDLE)) begin
            pending_d = 1'b1;
        end
    end

    // Outputs are registered from the next state; on SNAP->SHIFT the snapshot is not yet loaded.
    always_comb begin
        sel_idx  = HIGH_WORD_FIRST ? word_cnt_d : (LAST_IDX - word_cnt_d);
        src_word = (state_q == SNAP) ? shadow_q[sel_idx] : snap_q[sel_idx];
        busy_d   = (state_d != IDLE);
        wr_d     = (state_d == SHIFT);
        upd_d    = (state_d == UPDATE);
        dat_d    = wr_d ? src_word : dat_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pending_q  <= 1'b0;
            word_cnt_q <= '0;
            gap_cnt_q  <= '0;
            busy_q     <= 1'b0;
            wr_q       <= 1'b0;
            upd_q      <= 1'b0;
            dat_q      <= '0;
            for (int i = 0; i < NWORDS; i++) begin
                shadow_q[i] <= '0;
                snap_q[i]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            word_cnt_q <= word_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            busy_q     <= busy_d;
            wr_q       <= wr_d;
            upd_q      <= upd_d;
            dat_q      <= dat_d;
            shadow_q   <= shadow_d;
            snap_q     <= snap_d;
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = upd_q;
    assign coeff_wr_o     = wr_q;
    assign coeff_update_o = upd_q;
    assign coeff_dat_o    = dat_q;

`ifdef BIQUAD_COEFF_READBACK_EN
    logic [COEFF_BITS-1:0] active_q [NWORDS];
    logic [COEFF_BITS-1:0] active_d [NWORDS];
    logic [COEFF_BITS-1:0] rb_dat_q, rb_dat_d;

    // The active bank mirrors what the filter is actually running since the last strobe.
    always_comb begin
        active_d = active_q;
        if (state_q == UPDATE) begin
            active_d = snap_q;
        end
        rb_dat_d = (int'(rb_adr_i) < NWORDS) ? active_q[rb_adr_i[WIDX-1:0]] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rb_dat_q <= '0;
            for (int i = 0; i < NWORDS; i++) begin
                active_q[i] <= '0;
            end
        end else begin
            rb_dat_q <= rb_dat_d;
            active_q <= active_d;
        end
    end

    assign rb_dat_o = rb_dat_q;
`endif

endmodule

// File: tb/tb_biquad8_coeff_loader.sv
// Directed, table-driven bench for biquad8_coeff_loader (defaults: 18-bit words,
// two words, gap of 2). Readback checks are built only with BIQUAD_COEFF_READBACK_EN.
module tb_biquad8_coeff_loader;

    localparam int CB = 18;

    localparam logic [CB-1:0] D1 = 18'h1A2B3;
    localparam logic [CB-1:0] D0 = 18'h00F0F;
    localparam logic [CB-1:0] DF = 18'h3FFFF;
    localparam logic [CB-1:0] DA = 18'h2AAAA;

    typedef struct packed {
        logic          commit;
        logic          wr;
        logic          adr;
        logic [CB-1:0] dat;
        logic          e_busy;
        logic          e_wr;
        logic          e_upd;
        logic [CB-1:0] e_dat;
    } vec_t;

    logic          clk;
    logic          rst_n;
    logic [0:0]    host_adr_i;
    logic [CB-1:0] host_dat_i;
    logic          host_wr_i;
    logic          host_commit_i;
    logic          busy_o;
    logic          done_o;
    logic [CB-1:0] coeff_dat_o;
    logic          coeff_wr_o;
    logic          coeff_update_o;
`ifdef BIQUAD_COEFF_READBACK_EN
    logic [0:0]    rb_adr_i;
    logic [CB-1:0] rb_dat_o;
`endif

    int   n_vec;
    int   n_err;
    vec_t tbl [50];

    biquad8_coeff_loader dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .host_adr_i     (host_adr_i),
        .host_dat_i     (host_dat_i),
        .host_wr_i      (host_wr_i),
        .host_commit_i  (host_commit_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .coeff_dat_o    (coeff_dat_o),
        .coeff_wr_o     (coeff_wr_o),
`ifdef BIQUAD_COEFF_READBACK_EN
        .rb_adr_i       (rb_adr_i),
        .rb_dat_o       (rb_dat_o),
`endif
        .coeff_update_o (coeff_update_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic cm, input logic w, input logic a,
                                input logic [CB-1:0] d, input logic eb, input logic ew,
                                input logic eu, input logic [CB-1:0] ed);
        vec_t v;
        v.commit = cm;
        v.wr     = w;
        v.adr    = a;
        v.dat    = d;
        v.e_busy = eb;
        v.e_wr   = ew;
        v.e_upd  = eu;
        v.e_dat  = ed;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        host_commit_i = v.commit;
        host_wr_i     = v.wr;
        host_adr_i    = v.adr;
        host_dat_i    = v.dat;
    endtask

    // Packed as {busy, wr, update, done, data}.
    function automatic logic [CB+3:0] actualOut();
        return {busy_o, coeff_wr_o, coeff_update_o, done_o, coeff_dat_o};
    endfunction

    task automatic checkOutput(input string name, input logic [CB+3:0] act,
                               input logic [CB+3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got busy/wr/upd/done=%b dat=%h, expected busy/wr/upd/done=%b dat=%h",
                     name, act[CB+3:CB], act[CB-1:0], exp[CB+3:CB], exp[CB-1:0]);
        end
    endtask

    task automatic runVectors(input int lo, input int hi, input string tag);
        for (int i = lo; i <= hi; i++) begin
            @(posedge clk);
            #1;
            applyStimulus(tbl[i]);
            @(negedge clk);
            checkOutput($sformatf("%s_vec%0d", tag, i), actualOut(),
                        {tbl[i].e_busy, tbl[i].e_wr, tbl[i].e_upd, tbl[i].e_upd, tbl[i].e_dat});
        end
    endtask

    task automatic idleCycle();
        @(posedge clk);
        #1;
        host_commit_i = 1'b0;
        host_wr_i     = 1'b0;
    endtask

    initial begin
        logic saw_upd;
        n_vec = 0;
        n_err = 0;

        // Basic load, then a write during SHIFT that must not reach the in-flight sequence.
        tbl[0]  = mk(0, 1, 1, D1, 0, 0, 0, '0);
        tbl[1]  = mk(0, 1, 0, D0, 0, 0, 0, '0);
        tbl[2]  = mk(1, 0, 0, '0, 0, 0, 0, '0);
        tbl[3]  = mk(0, 0, 0, '0, 1, 0, 0, '0);
        tbl[4]  = mk(0, 1, 0, DF, 1, 1, 0, D1);
        tbl[5]  = mk(0, 0, 0, '0, 1, 1, 0, D0);
        tbl[6]  = mk(0, 0, 0, '0, 1, 0, 0, D0);
        tbl[7]  = mk(0, 0, 0, '0, 1, 0, 0, D0);
        tbl[8]  = mk(0, 0, 0, '0, 1, 0, 1, D0);
        tbl[9]  = mk(0, 0, 0, '0, 0, 0, 0, D0);
        // Follow-up commit picks up the late write.
        tbl[10] = mk(1, 0, 0, '0, 0, 0, 0, D0);
        tbl[11] = mk(0, 0, 0, '0, 1, 0, 0, D0);
        tbl[12] = mk(0, 0, 0, '0, 1, 1, 0, D1);
        tbl[13] = mk(0, 0, 0, '0, 1, 1, 0, DF);
        tbl[14] = mk(0, 0, 0, '0, 1, 0, 0, DF);
        tbl[15] = mk(0, 0, 0, '0, 1, 0, 0, DF);
        tbl[16] = mk(0, 0, 0, '0, 1, 0, 1, DF);
        tbl[17] = mk(0, 0, 0, '0, 0, 0, 0, DF);
        // Commits at cycles 0, 3, 4 collapse into one extra sequence; SNAP at cycle 8.
        tbl[18] = mk(1, 0, 0, '0, 0, 0, 0, DF);
        tbl[19] = mk(0, 0, 0, '0, 1, 0, 0, DF);
        tbl[20] = mk(0, 0, 0, '0, 1, 1, 0, D1);
        tbl[21] = mk(1, 0, 0, '0, 1, 1, 0, DF);
        tbl[22] = mk(1, 0, 0, '0, 1, 0, 0, DF);
        tbl[23] = mk(0, 1, 1, DA, 1, 0, 0, DF);
        tbl[24] = mk(0, 0, 0, '0, 1, 0, 1, DF);
        tbl[25] = mk(0, 0, 0, '0, 0, 0, 0, DF);
        tbl[26] = mk(0, 0, 0, '0, 1, 0, 0, DF);
        tbl[27] = mk(0, 0, 0, '0, 1, 1, 0, DA);
        tbl[28] = mk(0, 0, 0, '0, 1, 1, 0, DF);
        tbl[29] = mk(0, 0, 0, '0, 1, 0, 0, DF);
        tbl[30] = mk(0, 0, 0, '0, 1, 0, 0, DF);
        tbl[31] = mk(0, 0, 0, '0, 1, 0, 1, DF);
        tbl[32] = mk(0, 0, 0, '0, 0, 0, 0, DF);
        tbl[33] = mk(0, 0, 0, '0, 0, 0, 0, DF);
        // Commit coincident with UPDATE is kept as pending.
        tbl[34] = mk(1, 0, 0, '0, 0, 0, 0, DF);
        tbl[35] = mk(0, 0, 0, '0, 1, 0, 0, DF);
        tbl[36] = mk(0, 0, 0, '0, 1, 1, 0, DA);
        tbl[37] = mk(0, 0, 0, '0, 1, 1, 0, DF);
        tbl[38] = mk(0, 0, 0, '0, 1, 0, 0, DF);
        tbl[39] = mk(0, 0, 0, '0, 1, 0, 0, DF);
        tbl[40] = mk(1, 0, 0, '0, 1, 0, 1, DF);
        tbl[41] = mk(0, 0, 0, '0, 0, 0, 0, DF);
        tbl[42] = mk(0, 0, 0, '0, 1, 0, 0, DF);
        tbl[43] = mk(0, 0, 0, '0, 1, 1, 0, DA);
        tbl[44] = mk(0, 0, 0, '0, 1, 1, 0, DF);
        tbl[45] = mk(0, 0, 0, '0, 1, 0, 0, DF);
        tbl[46] = mk(0, 0, 0, '0, 1, 0, 0, DF);
        tbl[47] = mk(0, 0, 0, '0, 1, 0, 1, DF);
        tbl[48] = mk(0, 0, 0, '0, 0, 0, 0, DF);
        tbl[49] = mk(0, 0, 0, '0, 0, 0, 0, DF);

        rst_n         = 1'b0;
        host_adr_i    = '0;
        host_dat_i    = '0;
        host_wr_i     = 1'b0;
        host_commit_i = 1'b0;
`ifdef BIQUAD_COEFF_READBACK_EN
        rb_adr_i      = 1'b1;
`endif

        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput($sformatf("reset_idle%0d", i), actualOut(), '0);
        end

`ifdef BIQUAD_COEFF_READBACK_EN
        @(negedge clk);
        n_vec++;
        if (rb_dat_o !== '0) begin
            n_err++;
            $display("[TB] FAIL rb_before_update: got %h, expected %h", rb_dat_o, 18'h0);
        end
`endif

        runVectors(0, 49, "main");

        // Reset mid-sequence: drop rst_n during the second shifted word.
        @(posedge clk);
        #1;
        host_commit_i = 1'b1;
        idleCycle();
        idleCycle();
        idleCycle();
        @(negedge clk);
        n_vec++;
        if (coeff_wr_o !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL midseq_wr_before_reset: got %b, expected %b", coeff_wr_o, 1'b1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_outputs", actualOut(), '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        saw_upd = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (coeff_update_o || done_o || busy_o) saw_upd = 1'b1;
        end
        n_vec++;
        if (saw_upd !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL no_update_after_reset: got %b, expected %b", saw_upd, 1'b0);
        end

        runVectors(0, 9, "post_reset");

`ifdef BIQUAD_COEFF_READBACK_EN
        @(posedge clk);
        #1;
        rb_adr_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (rb_dat_o !== D1) begin
            n_err++;
            $display("[TB] FAIL rb_adr1: got %h, expected %h", rb_dat_o, D1);
        end
        #1;
        rb_adr_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (rb_dat_o !== D0) begin
            n_err++;
            $display("[TB] FAIL rb_adr0: got %h, expected %h", rb_dat_o, D0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
